// File: rtl/ysyx_2022040010_dcache_axi_bridge.sv
// Dcache memory-side bridge: dirty-victim write-back and line refill over a
// single-beat AXI4 master port, one outstanding miss at a time.
module ysyx_2022040010_dcache_axi_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  miss_req,
  input  logic [ADDR_W-1:0]     miss_addr,
  input  logic                  miss_dirty,
  input  logic [ADDR_W-1:0]     victim_addr,
  output logic                  miss_ready,
  output logic                  write_back,
  input  logic [DATA_W-1:0]     cacheline_old,
  output logic                  refresh,
  output logic [DATA_W-1:0]     cacheline_new,
  output logic                  refill_done,
  output logic                  bus_err,
  output logic                  awvalid,
  input  logic                  awready,
  output logic [ADDR_W-1:0]     awaddr,
  output logic [7:0]            awlen,
  output logic [2:0]            awsize,
  output logic [1:0]            awburst,
  output logic                  wvalid,
  input  logic                  wready,
  output logic [DATA_W-1:0]     wdata,
  output logic [DATA_W/8-1:0]   wstrb,
  output logic                  wlast,
  input  logic                  bvalid,
  output logic                  bready,
  input  logic [1:0]            bresp,
  output logic                  arvalid,
  input  logic                  arready,
  output logic [ADDR_W-1:0]     araddr,
  output logic [7:0]            arlen,
  output logic [2:0]            arsize,
  output logic [1:0]            arburst,
  input  logic                  rvalid,
  output logic                  rready,
  input  logic [DATA_W-1:0]     rdata,
  input  logic [1:0]            rresp,
  input  logic                  rlast
);

  typedef enum logic [2:0] {
    S_IDLE, S_WB_RD, S_WB_CAP, S_WB_AW, S_WB_B, S_RD_AR, S_RD_R, S_REFILL
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   miss_line_q, miss_line_d;
  logic [ADDR_W-1:0]   victim_line_q, victim_line_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   line_q, line_d;
  logic                aw_done_q, aw_done_d;
  logic                w_done_q, w_done_d;
  logic                bus_err_q, bus_err_d;
  logic                unused_inputs;

  // Single-beat lines: rlast and the byte offsets carry no information here.
  assign unused_inputs = ^{rlast, miss_addr[2:0], victim_addr[2:0]};

  always_comb begin
    state_d       = state_q;
    miss_line_d   = miss_line_q;
    victim_line_d = victim_line_q;
    wdata_d       = wdata_q;
    line_d        = line_q;
    aw_done_d     = aw_done_q;
    w_done_d      = w_done_q;
    bus_err_d     = bus_err_q;
    case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          miss_line_d   = {miss_addr[ADDR_W-1:3], 3'b000};
          victim_line_d = {victim_addr[ADDR_W-1:3], 3'b000};
          aw_done_d     = 1'b0;
          w_done_d      = 1'b0;
          state_d       = miss_dirty ? S_WB_RD : S_RD_AR;
        end
      end
      S_WB_RD: state_d = S_WB_CAP;
      S_WB_CAP: begin
        // The array's registered bank read is visible in this second cycle.
        wdata_d = cacheline_old;
        state_d = S_WB_AW;
      end
      S_WB_AW: begin
        aw_done_d = aw_done_q | awready;
        w_done_d  = w_done_q | wready;
        if (aw_done_d && w_done_d) begin
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          state_d   = S_WB_B;
        end
      end
      S_WB_B: begin
        if (bvalid) begin
          if (bresp != 2'b00) bus_err_d = 1'b1;
          state_d = S_RD_AR;
        end
      end
      S_RD_AR: if (arready) state_d = S_RD_R;
      S_RD_R: begin
        if (rvalid) begin
          line_d = rdata;
          if (rresp != 2'b00) bus_err_d = 1'b1;
          state_d = S_REFILL;
        end
      end
      S_REFILL: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      miss_line_q   <= '0;
      victim_line_q <= '0;
      wdata_q       <= '0;
      line_q        <= '0;
      aw_done_q     <= 1'b0;
      w_done_q      <= 1'b0;
      bus_err_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      miss_line_q   <= miss_line_d;
      victim_line_q <= victim_line_d;
      wdata_q       <= wdata_d;
      line_q        <= line_d;
      aw_done_q     <= aw_done_d;
      w_done_q      <= w_done_d;
      bus_err_q     <= bus_err_d;
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid & ready are
  // both 1; valids depend only on registered state, never on a ready input,
  // and stay high with stable payload until their own handshake completes.
  assign miss_ready    = (state_q == S_IDLE);
  assign write_back    = (state_q == S_WB_RD) || (state_q == S_WB_CAP);
  assign refresh       = (state_q == S_REFILL);
  assign refill_done   = (state_q == S_REFILL);
  assign cacheline_new = line_q;
  assign bus_err       = bus_err_q;

  assign awvalid = (state_q == S_WB_AW) && !aw_done_q;
  assign awaddr  = victim_line_q;
  assign awlen   = 8'd0;
  assign awsize  = 3'd3;
  assign awburst = 2'b01;

  assign wvalid  = (state_q == S_WB_AW) && !w_done_q;
  assign wdata   = wdata_q;
  assign wstrb   = '1;
  assign wlast   = 1'b1;

  assign bready  = (state_q == S_WB_B);

  assign arvalid = (state_q == S_RD_AR);
  assign araddr  = miss_line_q;
  assign arlen   = 8'd0;
  assign arsize  = 3'd3;
  assign arburst = 2'b01;

  assign rready  = (state_q == S_RD_R);

endmodule

// File: tb/tb_ysyx_2022040010_dcache_axi_bridge.sv
// Bench for the dcache AXI bridge: directed misses plus randomized traffic,
// checked every cycle against a transaction-level model of the miss flow.
module tb_ysyx_2022040010_dcache_axi_bridge;

  logic        clk = 1'b0;
  logic        rst;
  logic        miss_req, miss_dirty, miss_ready, write_back;
  logic [63:0] miss_addr, victim_addr, cacheline_old, cacheline_new;
  logic        refresh, refill_done, bus_err;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, wlast, rlast;
  logic [63:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen, wstrb;
  logic [2:0]  awsize, arsize;
  logic [1:0]  awburst, arburst, bresp, rresp;

  always #5 clk = ~clk;

  ysyx_2022040010_dcache_axi_bridge #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk(clk), .rst(rst),
    .miss_req(miss_req), .miss_addr(miss_addr), .miss_dirty(miss_dirty),
    .victim_addr(victim_addr), .miss_ready(miss_ready), .write_back(write_back),
    .cacheline_old(cacheline_old), .refresh(refresh), .cacheline_new(cacheline_new),
    .refill_done(refill_done), .bus_err(bus_err),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr), .awlen(awlen),
    .awsize(awsize), .awburst(awburst),
    .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .bvalid(bvalid), .bready(bready), .bresp(bresp),
    .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
    .arsize(arsize), .arburst(arburst),
    .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp), .rlast(rlast)
  );

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model / scoreboard ----------------
  logic [63:0] exp_q[$];
  logic [63:0] exp_v;
  bit          busy = 0, dirty_m = 0, err_m = 0;
  bit          aw_seen = 0, w_seen = 0, b_seen = 0, ar_seen = 0, r_seen = 0;
  bit          acc_hs = 0, b_hs = 0, r_hs = 0;
  logic [63:0] miss_line_m = '0, victim_line_m = '0, old_m = '0, arr_line = '0;
  logic [63:0] last_refill_m = '0, last_araddr = '0, last_awaddr = '0, last_wdata = '0;
  int          wb_cnt = 0, busy_cyc = 0, cyc = 0, acc_cyc = 0, ref_cyc = 0;
  int          acc_cnt = 0, ref_cnt = 0, aborted = 0, aw_hi = 0, w_hi = 0, last_wb = 0;

  // stimulus state
  logic [63:0] victim_data;
  bit          rand_mode = 0, r_hold = 0, force_rvalid = 0;
  int          aw_delay = 0, aw_cnt = 0;
  logic [1:0]  bresp_cfg = 2'b00, rresp_cfg = 2'b00;
  logic [63:0] rdata_cfg = '0;

  always @(negedge clk) begin
    if (rst) begin
      if (busy) aborted++;
      busy = 0; dirty_m = 0; err_m = 0; wb_cnt = 0; busy_cyc = 0;
      aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
      acc_hs = 0; b_hs = 0; r_hs = 0;
      last_refill_m = '0;
      exp_q.delete();
    end else begin
      cyc++;
      check("miss_ready", miss_ready, !busy);
      check("write_back", write_back, busy && dirty_m && wb_cnt < 2);
      check("awvalid", awvalid, busy && dirty_m && wb_cnt == 2 && !aw_seen);
      check("wvalid", wvalid, busy && dirty_m && wb_cnt == 2 && !w_seen);
      check("bready", bready, busy && aw_seen && w_seen && !b_seen);
      check("arvalid", arvalid, busy && !ar_seen && (!dirty_m || b_seen));
      check("rready", rready, busy && ar_seen && !r_seen);
      check("refresh", refresh, busy && r_seen);
      check("refill_done", refill_done, busy && r_seen);
      check("bus_err", bus_err, err_m);
      if (awvalid) begin
        check("awaddr", awaddr, victim_line_m);
        check("aw_fixed", {awlen, awsize, awburst}, {8'd0, 3'd3, 2'b01});
        last_awaddr = awaddr; aw_hi++;
      end
      if (wvalid) begin
        check("wdata", wdata, old_m);
        check("w_fixed", {wstrb, wlast}, {8'hff, 1'b1});
        last_wdata = wdata; w_hi++;
      end
      if (arvalid) begin
        check("araddr", araddr, miss_line_m);
        check("ar_fixed", {arlen, arsize, arburst}, {8'd0, 3'd3, 2'b01});
        last_araddr = araddr;
      end
      if (refresh) begin
        if (exp_q.size() == 0) check("refill_unexpected", refresh, 1'b0);
        else begin
          exp_v = exp_q.pop_front();
          check("cacheline_new", cacheline_new, exp_v);
          last_refill_m = exp_v;
        end
        last_wb = wb_cnt; ref_cyc = cyc; ref_cnt++;
      end else begin
        check("cacheline_hold", cacheline_new, last_refill_m);
      end
      if (busy) busy_cyc++;
      if (busy_cyc == 400) check("busy_timeout", busy_cyc, 0);
      // events that take effect at the coming rising edge
      acc_hs = miss_req && miss_ready;
      b_hs   = bvalid && bready;
      r_hs   = rvalid && rready;
      if (write_back) wb_cnt++;
      if (awvalid && awready) aw_seen = 1;
      if (wvalid && wready) w_seen = 1;
      if (b_hs) begin b_seen = 1; if (bresp != 2'b00) err_m = 1; end
      if (arvalid && arready) ar_seen = 1;
      if (r_hs) begin
        r_seen = 1; exp_q.push_back(rdata);
        if (rresp != 2'b00) err_m = 1;
      end
      if (refresh) begin busy = 0; busy_cyc = 0; end
      if (acc_hs) begin
        busy = 1; dirty_m = miss_dirty;
        miss_line_m   = miss_addr & ~64'h7;
        victim_line_m = victim_addr & ~64'h7;
        old_m = victim_data; arr_line = victim_data;
        aw_seen = 0; w_seen = 0; b_seen = 0; ar_seen = 0; r_seen = 0;
        wb_cnt = 0; aw_hi = 0; w_hi = 0; busy_cyc = 0;
        acc_cyc = cyc; acc_cnt++;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic slave_step();
    cacheline_old = (write_back && wb_cnt == 1) ? arr_line : {$urandom, $urandom};
    if (rand_mode) begin
      awready = ($urandom_range(0, 3) != 0);
      wready  = ($urandom_range(0, 3) != 0);
      arready = ($urandom_range(0, 3) != 0);
    end else begin
      awready = awvalid && (aw_cnt >= aw_delay);
      wready  = 1'b1;
      arready = 1'b1;
    end
    aw_cnt = awvalid ? aw_cnt + 1 : 0;
    if (b_hs || !busy) bvalid = 1'b0;
    if (!bvalid && busy && aw_seen && w_seen && !b_seen &&
        (!rand_mode || $urandom_range(0, 2) == 0)) begin
      bvalid = 1'b1;
      bresp  = rand_mode ? (($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00) : bresp_cfg;
    end
    if (r_hs || !busy) rvalid = 1'b0;
    if (!rvalid && busy && ar_seen && !r_seen && !r_hold &&
        (!rand_mode || $urandom_range(0, 2) == 0)) begin
      rvalid = 1'b1;
      rdata  = rand_mode ? {$urandom, $urandom} : rdata_cfg;
      rresp  = rand_mode ? (($urandom_range(0, 15) == 0) ? 2'b10 : 2'b00) : rresp_cfg;
    end
    if (force_rvalid) begin
      rvalid = 1'b1;
      rdata  = 64'hBADC_0FFE_E0DD_F00D;
      rresp  = 2'b00;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    slave_step();
  endtask

  task automatic issue(input logic [63:0] a, input bit d, input logic [63:0] v,
                       input logic [63:0] vd, input bit keep);
    int n;
    n = 0;
    miss_req = 1'b1; miss_addr = a; miss_dirty = d; victim_addr = v; victim_data = vd;
    do begin
      tick();
      n++;
    end while (!acc_hs && n < 500);
    check("accept", acc_hs, 1'b1);
    if (!keep) miss_req = 1'b0;
    miss_addr   = {$urandom, $urandom};
    victim_addr = {$urandom, $urandom};
    victim_data = {$urandom, $urandom};
    miss_dirty  = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_refills(input int target);
    int n;
    n = 0;
    while (ref_cnt < target && n < 2000) begin
      tick();
      n++;
    end
    check("refill_wait", ref_cnt, target);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    int base;
    rst = 1'b1;
    miss_req = 0; miss_addr = '0; miss_dirty = 0; victim_addr = '0; victim_data = '0;
    awready = 0; wready = 0; arready = 0; bvalid = 0; bresp = 0;
    rvalid = 0; rdata = '0; rresp = 0; rlast = 1'b1; cacheline_old = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_miss_ready", miss_ready, 1'b1);
    check("rst_strobes", {awvalid, wvalid, bready, arvalid, rready, refresh, refill_done, write_back}, 8'h00);
    check("rst_addrs", awaddr | araddr, 64'h0);
    check("rst_wdata", wdata, 64'h0);
    check("rst_line", cacheline_new, 64'h0);
    check("rst_bus_err", bus_err, 1'b0);

    // clean miss
    rdata_cfg = 64'hDEAD_BEEF_0123_4567;
    issue(64'h8000_1234, 1'b0, 64'h0, 64'h0, 1'b0);
    wait_refills(1);
    check("t1_araddr", last_araddr, 64'h8000_1230);
    check("t1_line", cacheline_new, 64'hDEAD_BEEF_0123_4567);
    check("t1_latency", ref_cyc - acc_cyc, 3);
    check("t1_ready", miss_ready, 1'b1);

    // dirty miss
    rdata_cfg = 64'h5555_6666_7777_8888;
    issue(64'h8000_2008, 1'b1, 64'h8000_0040, 64'h1111_2222_3333_4444, 1'b0);
    wait_refills(2);
    check("t2_wb_cycles", last_wb, 2);
    check("t2_awaddr", last_awaddr, 64'h8000_0040);
    check("t2_wdata", last_wdata, 64'h1111_2222_3333_4444);
    check("t2_araddr", last_araddr, 64'h8000_2008);
    check("t2_latency", ref_cyc - acc_cyc, 7);
    check("t2_line", cacheline_new, 64'h5555_6666_7777_8888);

    // awready held off 3 cycles, wready immediate
    aw_delay = 3;
    issue(64'h8000_3010, 1'b1, 64'h8000_0087, 64'hA5A5_0000_FFFF_5A5A, 1'b0);
    wait_refills(3);
    check("t3_aw_cycles", aw_hi, 4);
    check("t3_w_cycles", w_hi, 1);
    check("t3_awaddr", last_awaddr, 64'h8000_0080);
    aw_delay = 0;

    // SLVERR on write-back response; refill still completes, error sticks
    bresp_cfg = 2'b10;
    issue(64'h8000_4000, 1'b1, 64'h8000_0100, 64'h0BAD_0BAD_0BAD_0BAD, 1'b0);
    wait_refills(4);
    bresp_cfg = 2'b00;
    check("t4_bus_err", bus_err, 1'b1);
    issue(64'h8000_5000, 1'b0, 64'h0, 64'h0, 1'b0);
    wait_refills(5);
    check("t4_sticky", bus_err, 1'b1);

    // reset while waiting for read data
    r_hold = 1;
    issue(64'h8000_6018, 1'b0, 64'h0, 64'h0, 1'b0);
    n = 0;
    while (!ar_seen && n < 50) begin tick(); n++; end
    check("t5_in_rd_r", rready, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    r_hold = 0;
    check("t5_miss_ready", miss_ready, 1'b1);
    check("t5_rready", rready, 1'b0);
    check("t5_bus_err", bus_err, 1'b0);
    check("t5_line", cacheline_new, 64'h0);
    check("t5_araddr", araddr, 64'h0);
    base = ref_cnt;
    force_rvalid = 1;
    repeat (3) tick();
    force_rvalid = 0;
    tick();
    check("t5_no_refill", ref_cnt, base);
    check("t5_idle", miss_ready, 1'b1);

    // back-to-back with miss_req held high
    rdata_cfg = 64'h0123_4567_89AB_CDEF;
    issue(64'h8000_7000, 1'b0, 64'h0, 64'h0, 1'b1);
    issue(64'h8000_7040, 1'b1, 64'h8000_0200, 64'hCAFE_F00D_CAFE_F00D, 1'b0);
    check("t6_gap", acc_cyc - ref_cyc, 1);
    wait_refills(base + 2);
    check("t6_line", cacheline_new, 64'h0123_4567_89AB_CDEF);

    // randomized traffic
    rand_mode = 1;
    for (int i = 0; i < 250; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      issue({$urandom, $urandom}, 1'($urandom_range(0, 1)), {$urandom, $urandom},
            {$urandom, $urandom}, 1'($urandom_range(0, 1)));
    end
    miss_req = 1'b0;
    tick();
    tick();
    wait_refills(acc_cnt - aborted);
    repeat (3) tick();
    check("final_queue_empty", exp_q.size(), 0);
    check("final_refill_count", ref_cnt, acc_cnt - aborted);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ysyx_2022040010_dcache_axi_bridge.md
Name: ysyx_2022040010_dcache_axi_bridge

Overview:
Memory-side counterpart of the dcache data array: it services line refills and dirty-victim write-backs over a single-beat AXI4 master port. On a miss it optionally reads the 8-byte victim line out of the data array (write_back), writes it to memory, fetches the new line, and presents it to the data array (refresh/cacheline_new). It sits between the dcache controller and the core's AXI arbiter; one outstanding miss at a time.

Parameters:
ADDR_W, 64, AXI address width
DATA_W, 64, line and beat width (one line = one beat)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_req  in  1  controller requests a refill (held until miss_ready & miss_req sampled)
miss_addr  in  64  missing address; bits [2:0] ignored
miss_dirty  in  1  victim line is dirty, write back first
victim_addr  in  64  victim line address ({victim tag, index, 3'b0})
miss_ready  out  1  bridge idle, request accepted this cycle if miss_req=1
write_back  out  1  data array read-out enable for victim line
cacheline_old  in  64  victim line from data array (valid only while write_back=1)
refresh  out  1  one-cycle data array refill strobe
cacheline_new  out  64  refill line
refill_done  out  1  one-cycle pulse, same cycle as refresh
bus_err  out  1  sticky: any non-OKAY bresp/rresp since reset
awvalid out 1; awready in 1; awaddr out 64; awlen out 8 (=0); awsize out 3 (=3); awburst out 2 (=01)
wvalid out 1; wready in 1; wdata out 64; wstrb out 8 (=8'hff); wlast out 1 (=1)
bvalid in 1; bready out 1; bresp in 2
arvalid out 1; arready in 1; araddr out 64; arlen out 8 (=0); arsize out 3 (=3); arburst out 2 (=01)
rvalid in 1; rready out 1; rdata in 64; rresp in 2; rlast in 1

Behaviour:
- Reset: state=IDLE; all valid/ready/strobe outputs 0, cacheline_new=0, awaddr/araddr/wdata=0, bus_err=0. Reset mid-transaction aborts immediately to IDLE with these values (no drain).
- Addresses forced 8-byte aligned: addr & ~64'h7, latched at accept; inputs ignored afterwards.
- States: IDLE, WB_RD, WB_CAP, WB_AW, WB_B, RD_AR, RD_R, REFILL.
- IDLE: miss_ready=1. miss_req=1 -> latch addresses; miss_dirty ? WB_RD : RD_AR.
- WB_RD: write_back=1 (array performs its registered bank read). -> WB_CAP.
- WB_CAP: write_back=1 (array gates cacheline_old with write_back); wdata <= cacheline_old at cycle end. -> WB_AW.
- WB_AW: awvalid and wvalid raised together; each drops independently on its own handshake; awaddr=victim line, wdata stable until accepted. -> WB_B in the cycle after both handshakes complete (same cycle if simultaneous).
- WB_B: bready=1; bvalid -> RD_AR; bresp!=0 sets bus_err, flow continues.
- RD_AR: arvalid=1, araddr=miss line; arready -> RD_R.
- RD_R: rready=1; on rvalid capture rdata into cacheline_new; rresp!=0 sets bus_err; rlast treated as 1 (single beat). -> REFILL.
- REFILL: refresh=1, refill_done=1 exactly one cycle; cacheline_new holds value until next refill. -> IDLE.
- Valid signals never deassert before handshake; no combinational path from any ready input to a valid output.
- Minimum latency clean miss (all readies 1, rvalid next cycle): accept->refresh = 3 cycles; dirty adds 4 + bvalid delay.
- refresh and write_back never asserted in the same cycle.

Test Plan:
- Clean miss, miss_addr=64'h8000_1234, arready=1, rdata=64'hDEAD_BEEF_0123_4567 one cycle later -> araddr=64'h8000_1230, refresh/refill_done 1 cycle with cacheline_new=DEAD_BEEF_0123_4567, miss_ready back to 1.
- Dirty miss, victim_addr=64'h8000_0040, cacheline_old=64'h1111_2222_3333_4444 -> write_back high exactly 2 cycles, awaddr=8000_0040, wdata=1111_2222_3333_4444, wstrb=ff; AR issued only after bvalid.
- awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles, WB_B entered once both done.
- bresp=2'b10 on write-back, rresp=0 -> bus_err=1 sticky, refill still completes.
- Reset asserted in RD_R with rvalid=0 -> next cycle all outputs at reset values, miss_ready=1; later rvalid ignored.
- Back-to-back: miss_req held high -> second request accepted the cycle after REFILL, no lost or duplicated refresh.
